nes_ctrl_port: RTL and testbench



---
 rtl/nes_ctrl_port.sv | 167 ++++++++++++++++
 tb/tb_nes_ctrl_port.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_ctrl_port.sv
// NES controller-port stage: $4016/$4017 decode, pad strobe/shift clocks, serial data sync.
// Optional shadow button capture is built when CTRL_SHADOW_EN is defined.
module nes_ctrl_port #(
    parameter int unsigned PULSE_CYCLES  = 6,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  OPEN_BUS      = 8'h40
) (
    input  logic        clk_cpu,
    input  logic        rst_n,
    input  logic        cpu_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    input  logic [1:0]  ctrl_data,
    output logic [1:0]  ctrl_out,
    output logic [1:0]  ctrl_strobe,
    output logic [7:0]  buttons0,
    output logic [7:0]  buttons1,
    output logic        buttons_vld
);

    typedef enum logic [1:0] {StIdle, StPulse, StSettle} state_e;

    localparam logic [7:0] PulseLoad  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

    state_e     state_q [2];
    state_e     state_d [2];
    logic [7:0] cnt_q   [2];
    logic [7:0] cnt_d   [2];
    logic [1:0] pend_q, pend_d;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] hold_q;
    logic [1:0] pad_bit, cur_bit, rd;
    logic       strobe_q, strobe_wr;
    logic       unused_data;

    assign rd[0]       = cpu_en && cpu_rw && (cpu_addr == 16'h4016);
    assign rd[1]       = cpu_en && cpu_rw && (cpu_addr == 16'h4017);
    assign strobe_wr   = cpu_en && !cpu_rw && (cpu_addr == 16'h4016);
    assign pad_bit     = ~sync2_q;
    assign ctrl_strobe = {2{strobe_q}};
    assign unused_data = ^cpu_data_i[7:1];

    // Bit returned to the CPU: live while idle or strobed, frozen during a shift sequence.
    always_comb begin
        cur_bit  = '0;
        ctrl_out = '0;
        for (int p = 0; p < 2; p++) begin
            cur_bit[p]  = (state_q[p] == StIdle || strobe_q) ? pad_bit[p] : hold_q[p];
            ctrl_out[p] = (state_q[p] == StPulse);
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            unique case (state_q[p])
                StIdle: begin
                    if (rd[p] && !strobe_q) begin
                        state_d[p] = StPulse;
                        cnt_d[p]   = PulseLoad;
                    end
                end
                StPulse: begin
                    if (rd[p] && !strobe_q) pend_d[p] = 1'b1;
                    if (cnt_q[p] == 8'd0) begin
                        state_d[p] = StSettle;
                        cnt_d[p]   = SettleLoad;
                    end else begin
                        cnt_d[p] = cnt_q[p] - 8'd1;
                    end
                end
                StSettle: begin
                    if (cnt_q[p] == 8'd0) begin
                        pend_d[p] = 1'b0;
                        // A read landing on the final settle cycle is chained like a pending one.
                        if ((pend_q[p] || rd[p]) && !strobe_q) begin
                            state_d[p] = StPulse;
                            cnt_d[p]   = PulseLoad;
                        end else begin
                            state_d[p] = StIdle;
                        end
                    end else begin
                        cnt_d[p] = cnt_q[p] - 8'd1;
                        if (rd[p] && !strobe_q) pend_d[p] = 1'b1;
                    end
                end
                default: state_d[p] = StIdle;
            endcase
            if (strobe_q) pend_d[p] = 1'b0;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= StIdle;
                cnt_q[p]   <= 8'd0;
            end
            pend_q     <= 2'b00;
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            hold_q     <= 2'b00;
            strobe_q   <= 1'b0;
            cpu_data_o <= 8'h00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
            pend_q  <= pend_d;
            sync1_q <= ctrl_data;
            sync2_q <= sync1_q;
            hold_q  <= cur_bit;
            if (strobe_wr) strobe_q <= cpu_data_i[0];
            if (rd[0])      cpu_data_o <= {OPEN_BUS[7:1], cur_bit[0]};
            else if (rd[1]) cpu_data_o <= {OPEN_BUS[7:1], cur_bit[1]};
        end
    end

`ifdef CTRL_SHADOW_EN
    logic [7:0] sh_q  [2];
    logic [3:0] n_q   [2];
    logic [7:0] btn_q [2];
    logic       vld_q;

    always_ff @(posedge clk_cpu) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                sh_q[p]  <= 8'h00;
                n_q[p]   <= 4'd0;
                btn_q[p] <= 8'h00;
            end
            vld_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                // Shift right so the first bit read (A) ends up in bit 0.
                if (rd[p] && !strobe_q && n_q[p] < 4'd8) begin
                    sh_q[p] <= {cur_bit[p], sh_q[p][7:1]};
                    n_q[p]  <= n_q[p] + 4'd1;
                end
            end
            if (strobe_wr && cpu_data_i[0]) begin
                for (int p = 0; p < 2; p++) begin
                    if (n_q[p] == 4'd8) btn_q[p] <= sh_q[p];
                    n_q[p] <= 4'd0;
                end
                vld_q <= (n_q[0] == 4'd8) || (n_q[1] == 4'd8);
            end
        end
    end

    assign buttons0    = btn_q[0];
    assign buttons1    = btn_q[1];
    assign buttons_vld = vld_q;
`else
    assign buttons0    = 8'h00;
    assign buttons1    = 8'h00;
    assign buttons_vld = 1'b0;
`endif

endmodule

// File: tb/tb_nes_ctrl_port.sv
// Self-checking bench for nes_ctrl_port with a behavioural joypad model on each connector.
module tb_nes_ctrl_port;

    logic        clk_cpu = 1'b0;
    logic        rst_n, cpu_en, cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_i, cpu_data_o, buttons0, buttons1;
    logic [1:0]  ctrl_data, ctrl_out, ctrl_strobe;
    logic        buttons_vld;

    int errors = 0;
    int checks = 0;

    // Joypad model: buttons as a byte (1 = pressed), shift index advanced on each clock rise.
    logic [7:0] btn [2];
    int         pad_idx [2] = '{0, 0};
    int         pulses  [2] = '{0, 0};
    logic [1:0] out_prev = 2'b00;
    logic       force_low;

    nes_ctrl_port dut (
        .clk_cpu    (clk_cpu),
        .rst_n      (rst_n),
        .cpu_en     (cpu_en),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .ctrl_data  (ctrl_data),
        .ctrl_out   (ctrl_out),
        .ctrl_strobe(ctrl_strobe),
        .buttons0   (buttons0),
        .buttons1   (buttons1),
        .buttons_vld(buttons_vld)
    );

    always #5 clk_cpu = ~clk_cpu;

    function automatic logic pressed(int p);
        if (ctrl_strobe[p]) return btn[p][0];
        if (pad_idx[p] < 8) return btn[p][pad_idx[p]];
        return 1'b1;
    endfunction

    always_comb begin
        ctrl_data = 2'b00;
        for (int p = 0; p < 2; p++) ctrl_data[p] = force_low ? 1'b0 : ~pressed(p);
    end

    always @(posedge clk_cpu) begin
        out_prev <= ctrl_out;
        for (int p = 0; p < 2; p++) begin
            if (ctrl_out[p] && !out_prev[p]) pulses[p] <= pulses[p] + 1;
            if (ctrl_strobe[p]) pad_idx[p] <= 0;
            else if (ctrl_out[p] && !out_prev[p]) pad_idx[p] <= pad_idx[p] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_cpu);
            #1;
        end
    endtask

    task automatic bus(input logic [15:0] addr, input logic rw, input logic [7:0] data);
        cpu_en     = 1'b1;
        cpu_addr   = addr;
        cpu_rw     = rw;
        cpu_data_i = data;
        tick(1);
        cpu_en     = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_rw     = 1'b1;
        cpu_data_i = 8'h00;
    endtask

    function automatic logic [7:0] rd_exp(input logic b);
        return {7'b0100000, b};
    endfunction

    initial begin
        int   pb, gap, p;
        logic exp_b;
        logic [7:0] saved;

        cpu_en = 1'b0; cpu_addr = 16'h0; cpu_rw = 1'b1; cpu_data_i = 8'h0;
        btn[0] = 8'h00; btn[1] = 8'h00;
        force_low = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("rst_data", cpu_data_o, 8'h00);
        check("rst_out", ctrl_out, 2'b00);
        check("rst_strobe", ctrl_strobe, 2'b00);
        check("rst_btn0", buttons0, 8'h00);
        check("rst_btn1", buttons1, 8'h00);
        check("rst_vld", buttons_vld, 1'b0);
        rst_n = 1'b1;
        tick(3);
        bus(16'h4016, 1'b1, 8'h00);
        check("rst_read", cpu_data_o, 8'h41);
        tick(12);
        force_low = 1'b0;

        // Strobe held high: reads return live A and never clock the pads.
        btn[0] = 8'h01;
        btn[1] = 8'($urandom);
        bus(16'h4016, 1'b0, 8'h01);
        check("strobe_out", ctrl_strobe, 2'b11);
        tick(3);
        pb = pulses[0] + pulses[1];
        bus(16'h4016, 1'b1, 8'h00);
        check("strobe_rd0", cpu_data_o, 8'h41);
        bus(16'h4017, 1'b1, 8'h00);
        check("strobe_rd1", cpu_data_o, rd_exp(btn[1][0]));
        tick(8);
        check("strobe_noclk", ctrl_out, 2'b00);
        check("strobe_nopulse", pulses[0] + pulses[1], pb);
        bus(16'h4016, 1'b0, 8'h00);
        check("strobe_low", ctrl_strobe, 2'b00);
        tick(3);

        // Pulse shape on port 1.
        pb = pulses[0];
        exp_b = pressed(1);
        bus(16'h4017, 1'b1, 8'h00);
        check("shape_rd", cpu_data_o, rd_exp(exp_b));
        for (int i = 0; i < 6; i++) begin
            check("shape_hi", ctrl_out, 2'b10);
            tick(1);
        end
        check("shape_lo", ctrl_out, 2'b00);
        check("shape_p0", pulses[0], pb);
        tick(10);

        // Back-to-back reads on port 0: second is chained, third is dropped.
        btn[0] = 8'($urandom);
        btn[0][1] = ~btn[0][0];
        bus(16'h4016, 1'b0, 8'h01);
        bus(16'h4016, 1'b0, 8'h00);
        tick(3);
        pb = pulses[0];
        bus(16'h4016, 1'b1, 8'h00);
        check("b2b_rd1", cpu_data_o, rd_exp(btn[0][0]));
        tick(1);
        bus(16'h4016, 1'b1, 8'h00);
        check("b2b_rd2", cpu_data_o, rd_exp(btn[0][0]));
        tick(2);
        bus(16'h4016, 1'b1, 8'h00);
        check("b2b_rd3", cpu_data_o, rd_exp(btn[0][0]));
        tick(4);
        check("b2b_settle", ctrl_out[0], 1'b0);
        tick(1);
        check("b2b_rise2", ctrl_out[0], 1'b1);
        tick(6);
        check("b2b_fall2", ctrl_out[0], 1'b0);
        tick(20);
        check("b2b_count", pulses[0], pb + 2);
        exp_b = pressed(0);
        bus(16'h4016, 1'b1, 8'h00);
        check("b2b_next", cpu_data_o, rd_exp(exp_b));
        check("b2b_next_bit", exp_b, btn[0][2]);
        tick(12);

        // Random idle reads across both ports against the pad model.
        btn[0] = 8'($urandom);
        btn[1] = 8'($urandom);
        bus(16'h4016, 1'b0, 8'h01);
        bus(16'h4016, 1'b0, 8'h00);
        tick(3);
        for (int k = 0; k < 12; k++) begin
            p = int'($urandom_range(1, 0));
            exp_b = pressed(p);
            bus(p == 0 ? 16'h4016 : 16'h4017, 1'b1, 8'h00);
            check("rand_rd", cpu_data_o, rd_exp(exp_b));
            gap = int'($urandom_range(16, 11));
            tick(gap);
        end
        // Accesses outside the two ports must not disturb anything.
        saved = cpu_data_o;
        bus(16'h4017, 1'b0, 8'h01);
        bus(16'h4018, 1'b1, 8'h00);
        bus(16'h4116, 1'b0, 8'h01);
        check("other_data", cpu_data_o, saved);
        check("other_strobe", ctrl_strobe, 2'b00);
        check("other_out", ctrl_out, 2'b00);

        // Full shadow capture of port 0.
        btn[0] = 8'hA5;
        bus(16'h4016, 1'b0, 8'h01);
        bus(16'h4016, 1'b0, 8'h00);
        tick(3);
        for (int k = 0; k < 8; k++) begin
            bus(16'h4016, 1'b1, 8'h00);
            check("shadow_rd", cpu_data_o, rd_exp(btn[0][k]));
            tick(11);
        end
        bus(16'h4016, 1'b0, 8'h01);
`ifdef CTRL_SHADOW_EN
        check("shadow_btn0", buttons0, 8'hA5);
        check("shadow_vld", buttons_vld, 1'b1);
`else
        check("shadow_btn0", buttons0, 8'h00);
        check("shadow_vld", buttons_vld, 1'b0);
`endif
        tick(1);
        check("shadow_vld_end", buttons_vld, 1'b0);
        bus(16'h4016, 1'b0, 8'h00);
        tick(3);

        // Reset in the middle of a pulse.
        bus(16'h4016, 1'b1, 8'h00);
        tick(2);
        check("abort_hi", ctrl_out[0], 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("abort_lo", ctrl_out, 2'b00);
        rst_n = 1'b1;
        pb = pulses[0];
        tick(15);
        check("abort_nopend", pulses[0], pb);
        check("abort_idle_out", ctrl_out, 2'b00);
        exp_b = pressed(0);
        bus(16'h4016, 1'b1, 8'h00);
        check("abort_rd", cpu_data_o, rd_exp(exp_b));
        check("abort_rise", ctrl_out, 2'b01);
        tick(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
